// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD read/write engines: clock rate,
// microsecond-derived timing limits, read state encoding and RS encoding.
package lcd_pkg;

    localparam int FREQ      = 50_000_000;
    localparam int T1_US     = FREQ / 1_000_000;
    localparam int SETUP_US  = 1;
    localparam int E_HIGH_US = 3;
    localparam int E_GAP_US  = 1;
    localparam int HOLD_US   = 1;

    localparam int TIMER_W = 21;

    // A state exits on the cycle where the timer equals its limit, so a
    // limit of N cycles gives a state length of N+1 cycles.
    function automatic logic [TIMER_W-1:0] us_to_cycles(input int freq, input int us);
        return TIMER_W'((freq / 1_000_000) * us);
    endfunction

    localparam logic [TIMER_W-1:0] LIM_SETUP = us_to_cycles(FREQ, SETUP_US);
    localparam logic [TIMER_W-1:0] LIM_EHI   = us_to_cycles(FREQ, E_HIGH_US);
    localparam logic [TIMER_W-1:0] LIM_GAP   = us_to_cycles(FREQ, E_GAP_US);
    localparam logic [TIMER_W-1:0] LIM_HOLD  = us_to_cycles(FREQ, HOLD_US);

    // RS=0 addresses the busy flag / address counter, RS=1 addresses RAM data.
    localparam logic RS_INSTR = 1'b0;
    localparam logic RS_DATA  = 1'b1;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_ADDR_SETUP,
        RD_E_HIGH_HI,
        RD_E_GAP,
        RD_E_HIGH_LO,
        RD_HOLD,
        RD_DONE_TICK
    } rd_state_t;

endpackage

// File: rtl/lcd_nibble_sync.sv
// Two-flop synchronizer for the 4-bit LCD data bus, which is driven by the
// panel with no relation to the system clock.
module lcd_nibble_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    output logic [3:0] dout
);

    logic [3:0] meta;

    // First stage may go metastable; second stage presents a settled value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 4'h0;
            dout <= 4'h0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/lcd_read_transfer.sv
// HD44780-style 4-bit read cycle: RW high, two E pulses, upper nibble then
// lower nibble, assembled into readData with a one-cycle readDone pulse.
// Optional busy-flag polling is built when LCD_READ_BUSY_POLL_EN is defined.
//
// state         | meaning
// --------------+--------------------------------------------------------
// RD_IDLE       | all outputs low, waiting for readRequest
// RD_ADDR_SETUP | RS/RW presented, bus released, E low
// RD_E_HIGH_HI  | first E pulse; upper nibble sampled on the last cycle
// RD_E_GAP      | E low between nibbles, RS/RW held
// RD_E_HIGH_LO  | second E pulse; lower nibble sampled on the last cycle
// RD_HOLD       | E low, RS/RW held after final E fall
// RD_DONE_TICK  | readDone pulse, readData valid, RW and bus release drop
module lcd_read_transfer #(
    parameter int FREQ      = lcd_pkg::FREQ,
    parameter int SETUP_US  = lcd_pkg::SETUP_US,
    parameter int E_HIGH_US = lcd_pkg::E_HIGH_US,
    parameter int E_GAP_US  = lcd_pkg::E_GAP_US,
    parameter int HOLD_US   = lcd_pkg::HOLD_US
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        readRequest,
    input  logic        readRS,
    input  logic [3:0]  LCD_DIN,
`ifdef LCD_READ_BUSY_POLL_EN
    input  logic        pollBusy,
    output logic [15:0] pollCount,
`endif
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_E,
    output logic        busRelease,
    output logic [7:0]  readData,
    output logic        readDone,
    output logic        busy
);

    import lcd_pkg::*;

    localparam logic [TIMER_W-1:0] SETUP_LIM = us_to_cycles(FREQ, SETUP_US);
    localparam logic [TIMER_W-1:0] EHI_LIM   = us_to_cycles(FREQ, E_HIGH_US);
    localparam logic [TIMER_W-1:0] GAP_LIM   = us_to_cycles(FREQ, E_GAP_US);
    localparam logic [TIMER_W-1:0] HOLD_LIM  = us_to_cycles(FREQ, HOLD_US);

    rd_state_t          state;
    rd_state_t          state_next;
    logic [TIMER_W-1:0] timer;
    logic               timer_done;
    logic               accept;
    logic               rs_reg;
    logic [3:0]         din_sync;
    logic [3:0]         upper;
    logic [3:0]         lower;
    logic               poll_again;

    lcd_nibble_sync u_sync (
        .clk  (CLK),
        .rst  (RESET),
        .din  (LCD_DIN),
        .dout (din_sync)
    );

    assign accept = (state == RD_IDLE) && readRequest;

    // State register; reset drops E and RW immediately through the decode.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Per-state timer, cleared on every state entry and held at zero in idle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            timer <= '0;
        end else if ((state_next != state) || (state == RD_IDLE)) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Next-state and pin decode.
    always_comb begin
        state_next = state;
        timer_done = 1'b0;
        LCD_E      = 1'b0;
        LCD_RW     = 1'b0;
        LCD_RS     = RS_INSTR;
        busRelease = 1'b0;
        readDone   = 1'b0;
        busy       = (state != RD_IDLE);
        case (state)
            RD_IDLE: begin
                if (readRequest) state_next = RD_ADDR_SETUP;
            end
            RD_ADDR_SETUP: begin
                LCD_RS     = rs_reg;
                LCD_RW     = 1'b1;
                busRelease = 1'b1;
                timer_done = (timer == SETUP_LIM);
                if (timer_done) state_next = RD_E_HIGH_HI;
            end
            RD_E_HIGH_HI: begin
                LCD_RS     = rs_reg;
                LCD_RW     = 1'b1;
                LCD_E      = 1'b1;
                busRelease = 1'b1;
                timer_done = (timer == EHI_LIM);
                if (timer_done) state_next = RD_E_GAP;
            end
            RD_E_GAP: begin
                LCD_RS     = rs_reg;
                LCD_RW     = 1'b1;
                busRelease = 1'b1;
                timer_done = (timer == GAP_LIM);
                if (timer_done) state_next = RD_E_HIGH_LO;
            end
            RD_E_HIGH_LO: begin
                LCD_RS     = rs_reg;
                LCD_RW     = 1'b1;
                LCD_E      = 1'b1;
                busRelease = 1'b1;
                timer_done = (timer == EHI_LIM);
                if (timer_done) state_next = RD_HOLD;
            end
            RD_HOLD: begin
                LCD_RS     = rs_reg;
                LCD_RW     = 1'b1;
                busRelease = 1'b1;
                timer_done = (timer == HOLD_LIM);
                if (timer_done) state_next = poll_again ? RD_ADDR_SETUP : RD_DONE_TICK;
            end
            RD_DONE_TICK: begin
                LCD_RS     = rs_reg;
                readDone   = 1'b1;
                state_next = RD_IDLE;
            end
            default: begin
                state_next = RD_IDLE;
            end
        endcase
    end

    // Capture RS at accept, nibbles at the end of each E pulse, and publish
    // the byte on the HOLD exit so it is already valid in the done cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rs_reg   <= RS_INSTR;
            upper    <= 4'h0;
            lower    <= 4'h0;
            readData <= 8'h00;
        end else begin
            if (accept) rs_reg <= readRS;
            if ((state == RD_E_HIGH_HI) && timer_done) upper <= din_sync;
            if ((state == RD_E_HIGH_LO) && timer_done) lower <= din_sync;
            if ((state == RD_HOLD) && timer_done && !poll_again) readData <= {upper, lower};
        end
    end

`ifdef LCD_READ_BUSY_POLL_EN
    logic poll_en;

    // Repeat the status read while BF (bit 7, upper nibble MSB) is set.
    assign poll_again = poll_en && upper[3];

    // Poll mode latch and saturating count of busy status reads.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            poll_en   <= 1'b0;
            pollCount <= 16'h0000;
        end else if (accept) begin
            poll_en   <= pollBusy && (readRS == RS_INSTR);
            pollCount <= 16'h0000;
        end else if ((state == RD_HOLD) && timer_done && poll_again &&
                     (pollCount != 16'hFFFF)) begin
            pollCount <= pollCount + 16'd1;
        end
    end
`else
    assign poll_again = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_read_transfer.sv
// Self-checking bench for lcd_read_transfer. The reference is a timeline of
// expected pin levels derived from the microsecond durations of each phase.
module tb_lcd_read_transfer;

    // Phase lengths in cycles at 50 MHz: limit+1 for each timed phase.
    localparam int S  = 51;
    localparam int EH = 151;
    localparam int G  = 51;
    localparam int H  = 51;
    localparam int DONE_N = S + EH + G + EH + H + 1;   // 456
    localparam int UFALL  = S + EH + 1;                // edge where first E falls
    localparam int LFALL  = S + EH + G + EH + 1;       // edge where second E falls

    logic        CLK = 1'b0;
    logic        RESET;
    logic        readRequest;
    logic        readRS;
    logic [3:0]  LCD_DIN;
    logic        LCD_RS, LCD_RW, LCD_E, busRelease, readDone, busy;
    logic [7:0]  readData;
`ifdef LCD_READ_BUSY_POLL_EN
    logic        pollBusy;
    logic [15:0] pollCount;
`endif

    int vectors     = 0;
    int miscompares = 0;

    lcd_read_transfer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .readRequest (readRequest),
        .readRS      (readRS),
        .LCD_DIN     (LCD_DIN),
`ifdef LCD_READ_BUSY_POLL_EN
        .pollBusy    (pollBusy),
        .pollCount   (pollCount),
`endif
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_E       (LCD_E),
        .busRelease  (busRelease),
        .readData    (readData),
        .readDone    (readDone),
        .busy        (busy)
    );

    always #10 CLK = ~CLK;

    // Expected {E, RW, RS, busRelease, busy, readDone} after the n-th edge
    // counted from the accepting edge (n=1).
    function automatic logic [5:0] expect_pins(input int n, input logic rs);
        logic e, act;
        e   = (n > S && n <= S + EH) || (n > S + EH + G && n <= S + EH + G + EH);
        act = (n >= 1) && (n < DONE_N);
        return {e, act, act & rs, act, (n >= 1 && n <= DONE_N), (n == DONE_N)};
    endfunction

    // One full read from an idle DUT, checked every cycle. win selects the
    // sampling-window stimulus; hold_req keeps readRequest high afterwards.
    task automatic run_read(input logic rs, input logic [7:0] d, input bit hold_req,
                            input bit mid_pulse, input bit win);
        logic [5:0] exp_v, obs_v;
        int errs;
        errs = 0;
        readRequest = 1'b1;
        readRS      = rs;
        LCD_DIN     = win ? 4'($urandom) : d[7:4];
        for (int n = 1; n <= DONE_N + 1; n++) begin
            @(negedge CLK);
            if (!hold_req) readRequest = mid_pulse && (n == 200);
            readRS = 1'($urandom);
            if (!win) begin
                if (n == UFALL) LCD_DIN = d[3:0];
            end else begin
                if (n < UFALL - 3)           LCD_DIN = 4'($urandom);
                else if (n == UFALL - 3)     LCD_DIN = d[7:4];
                else if (n < UFALL)          LCD_DIN = ~d[7:4];
                else if (n < LFALL - 3)      LCD_DIN = 4'($urandom);
                else if (n == LFALL - 3)     LCD_DIN = d[3:0];
                else                         LCD_DIN = ~d[3:0];
            end
            exp_v = expect_pins(n, rs);
            obs_v = {LCD_E, LCD_RW, (n == DONE_N) ? 1'b0 : LCD_RS, busRelease, busy, readDone};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                if (errs < 4)
                    $display("FAIL pins cycle=%0d got E,RW,RS,REL,BUSY,DONE=%b want %b", n, obs_v, exp_v);
                errs++;
            end
            if (n == DONE_N) begin
                vectors++;
                if (readData !== d) begin
                    miscompares++;
                    $display("FAIL read_data got %h want %h", readData, d);
                end
            end
        end
    endtask

    task automatic test_reset();
        RESET       = 1'b1;
        readRequest = 1'b0;
        readRS      = 1'b0;
        LCD_DIN     = 4'h0;
`ifdef LCD_READ_BUSY_POLL_EN
        pollBusy    = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        vectors++;
        if ({LCD_E, LCD_RW, LCD_RS, busRelease, busy, readDone, readData} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_state got %b want all zero",
                     {LCD_E, LCD_RW, LCD_RS, busRelease, busy, readDone, readData});
        end
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        vectors++;
        if ({LCD_E, LCD_RW, busRelease, busy, readDone, readData} !== 13'h0) begin
            miscompares++;
            $display("FAIL idle_no_request got %b want all zero",
                     {LCD_E, LCD_RW, busRelease, busy, readDone, readData});
        end
    endtask

    // Reset inside the second E pulse before any read has completed: pins drop
    // without a clock edge and no byte is published.
    task automatic test_reset_mid();
        int dones;
        dones       = 0;
        readRequest = 1'b1;
        readRS      = 1'($urandom);
        LCD_DIN     = 4'($urandom);
        for (int n = 1; n <= 300; n++) begin
            @(negedge CLK);
            readRequest = 1'b0;
            LCD_DIN     = 4'($urandom);
        end
        vectors++;
        if ({LCD_E, LCD_RW} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_before_reset got E,RW=%b want 11", {LCD_E, LCD_RW});
        end
        #2 RESET = 1'b1;
        #1;
        vectors++;
        if ({LCD_E, LCD_RW, busRelease, busy, readDone} !== 5'b0) begin
            miscompares++;
            $display("FAIL async_reset_drop got E,RW,REL,BUSY,DONE=%b want 00000",
                     {LCD_E, LCD_RW, busRelease, busy, readDone});
        end
        @(negedge CLK);
        RESET = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (readDone || busy) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL reset_no_done got %0d active cycles want 0", dones);
        end
        vectors++;
        if (readData !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_read_data got %h want 00", readData);
        end
    endtask

    task automatic test_status_read();
        run_read(1'b0, 8'hA3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_data_read();
        run_read(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random_reads();
        for (int i = 0; i < 4; i++)
            run_read(1'($urandom), 8'($urandom), 1'b0, (i % 2) == 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int active;
        active = 0;
        run_read(1'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
        run_read(1'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
        run_read(1'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (busy) active++;
        end
        vectors++;
        if (active !== 0) begin
            miscompares++;
            $display("FAIL idle_after_b2b got %0d busy cycles want 0", active);
        end
    endtask

    task automatic test_sample_window();
        for (int i = 0; i < 3; i++)
            run_read(1'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
    endtask

`ifdef LCD_READ_BUSY_POLL_EN
    task automatic test_busy_poll();
        logic [7:0] seq [0:3];
        int rises, dones;
        logic prev_e;
        seq[0] = 8'hC7; seq[1] = 8'hF0; seq[2] = 8'h80; seq[3] = 8'h15;
        rises = 0; dones = 0; prev_e = 1'b0;
        pollBusy    = 1'b1;
        readRS      = 1'b0;
        readRequest = 1'b1;
        LCD_DIN     = seq[0][7:4];
        for (int c = 0; c < 4 * 460 + 40; c++) begin
            @(negedge CLK);
            readRequest = 1'b0;
            if (LCD_E && !prev_e) begin
                if (rises < 8) LCD_DIN = rises[0] ? seq[rises / 2][3:0] : seq[rises / 2][7:4];
                rises++;
            end
            if (readDone) begin
                dones++;
                vectors++;
                if ({readData, pollCount} !== {8'h15, 16'd3}) begin
                    miscompares++;
                    $display("FAIL poll_result got data=%h count=%0d want data=15 count=3",
                             readData, pollCount);
                end
            end
            prev_e = LCD_E;
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL poll_done_count got %0d want 1", dones);
        end
        pollBusy = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid();
        test_status_read();
        test_data_read();
        test_random_reads();
        test_back_to_back();
        test_sample_window();
`ifdef LCD_READ_BUSY_POLL_EN
        test_busy_poll();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
